// File: rtl/es_seq_pkg.sv
// Shared encodings for the expression-stack sequencer: command opcodes, ES micro-ops
// and the sequencer FSM state type.
package es_seq_pkg;

    typedef enum logic [2:0] {
        CMD_NOP     = 3'd0,
        CMD_PUSH    = 3'd1,
        CMD_POP     = 3'd2,
        CMD_DUP     = 3'd3,
        CMD_SWAP    = 3'd4,
        CMD_BINOP   = 3'd5,
        CMD_REPLACE = 3'd6,
        CMD_RSVD    = 3'd7
    } cmd_op_e;

    typedef enum logic [1:0] {
        ES_PUSH = 2'd0,
        ES_POP  = 2'd1,
        ES_WTOP = 2'd2,
        ES_HOLD = 2'd3
    } es_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP1  = 2'd1,
        ST_OP2  = 2'd2,
        ST_OP3  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/es_depth_tracker.sv
// Expression-stack entry counter plus push/pop legality flags.
// ES_DEPTH_CHECK_EN: saturating count with real legality flags; otherwise the count
// wraps and every operation is reported legal.
module es_depth_tracker #(
    parameter int DEPTH = 16,
    parameter int DW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_inc,
    input  logic          i_dec,
    output logic [DW-1:0] o_depth,
    output logic          o_ok_push,
    output logic          o_ok_pop1,
    output logic          o_ok_pop2
);

    localparam logic [DW-1:0] MAX = DW'(DEPTH);
    localparam logic [DW-1:0] ONE = DW'(1);

    logic [DW-1:0] r_depth;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_depth <= '0;
        end else if (i_inc && !i_dec) begin
`ifdef ES_DEPTH_CHECK_EN
            if (r_depth != MAX) r_depth <= r_depth + ONE;
`else
            r_depth <= r_depth + ONE;
`endif
        end else if (i_dec && !i_inc) begin
`ifdef ES_DEPTH_CHECK_EN
            if (r_depth != '0) r_depth <= r_depth - ONE;
`else
            r_depth <= r_depth - ONE;
`endif
        end
    end

    assign o_depth = r_depth;

`ifdef ES_DEPTH_CHECK_EN
    assign o_ok_push = (r_depth < MAX);
    assign o_ok_pop1 = (r_depth != '0);
    assign o_ok_pop2 = (r_depth > ONE);
`else
    assign o_ok_push = 1'b1;
    assign o_ok_pop1 = 1'b1;
    assign o_ok_pop2 = 1'b1;
`endif

endmodule

// File: rtl/es_sequencer.sv
// Expands one stack command per handshake into registered ESOp/ESAct/pushSrc cycles.
// Rejection of illegal depth commands is active only with ES_DEPTH_CHECK_EN defined.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | ready for a command; ES idle (hold)
// ST_OP1  | first micro-op (or NOP/err pulse) of the accepted command
// ST_OP2  | second micro-op of BINOP/SWAP
// ST_OP3  | third micro-op of SWAP
module es_sequencer
    import es_seq_pkg::*;
#(
    parameter int         WIDTH    = 16,
    parameter int         DEPTH    = 16,
    parameter logic [2:0] SRC_ALU  = 3'd1,
    parameter logic [2:0] SRC_TOSA = 3'd5,
    parameter logic [2:0] SRC_SEQ  = 3'd6
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_valid,
    input  logic [2:0]                   cmd_op,
    input  logic [2:0]                   cmd_src,
    output logic                         cmd_ready,
    input  logic [WIDTH-1:0]             tosRega,
    input  logic [WIDTH-1:0]             tosRegb,
    output logic [1:0]                   ESOp,
    output logic                         ESAct,
    output logic [2:0]                   pushSrc,
    output logic [WIDTH-1:0]             seq_data,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         done,
    output logic                         err
);

    localparam int DW = $clog2(DEPTH + 1);

    seq_state_e       r_state, w_state_nxt;
    cmd_op_e          r_op, w_op_nxt;
    es_op_e           r_esop, w_esop_nxt;
    logic             r_esact, w_esact_nxt;
    logic [2:0]       r_pushsrc, w_pushsrc_nxt;
    logic [WIDTH-1:0] r_seq_data, w_seq_nxt;
    logic [WIDTH-1:0] r_seq_a, r_seq_b;
    logic             r_done, w_done_nxt;
    logic             r_err, w_err_nxt;

    logic             w_inc, w_dec, w_legal;
    logic             w_ok_push, w_ok_pop1, w_ok_pop2;
    logic             w_accept;
    cmd_op_e          w_cmd;
    logic [DW-1:0]    w_depth;

    assign w_cmd    = cmd_op_e'(cmd_op);
    assign w_accept = (r_state == ST_IDLE) && cmd_valid;

    es_depth_tracker #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_depth (
        .clk       (clk),
        .reset     (reset),
        .i_inc     (w_inc),
        .i_dec     (w_dec),
        .o_depth   (w_depth),
        .o_ok_push (w_ok_push),
        .o_ok_pop1 (w_ok_pop1),
        .o_ok_pop2 (w_ok_pop2)
    );

    always_comb begin
        w_legal = 1'b1;
        case (w_cmd)
            CMD_PUSH:              w_legal = w_ok_push;
            CMD_POP, CMD_REPLACE:  w_legal = w_ok_pop1;
            CMD_DUP:               w_legal = w_ok_push && w_ok_pop1;
            CMD_BINOP, CMD_SWAP:   w_legal = w_ok_pop2;
            default:               w_legal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_op       <= CMD_NOP;
            r_esop     <= ES_HOLD;
            r_esact    <= 1'b0;
            r_pushsrc  <= '0;
            r_seq_data <= '0;
            r_seq_a    <= '0;
            r_seq_b    <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_op       <= w_op_nxt;
            r_esop     <= w_esop_nxt;
            r_esact    <= w_esact_nxt;
            r_pushsrc  <= w_pushsrc_nxt;
            r_seq_data <= w_seq_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            // SWAP operands must be the values at accept; the pop changes the ES top
            if (w_accept) begin
                r_seq_a <= tosRega;
                r_seq_b <= tosRegb;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_op_nxt      = r_op;
        w_esop_nxt    = ES_HOLD;
        w_esact_nxt   = 1'b0;
        w_pushsrc_nxt = '0;
        w_seq_nxt     = r_seq_data;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        w_inc         = 1'b0;
        w_dec         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_state_nxt = ST_OP1;
                    if (!w_legal) begin
                        w_err_nxt = 1'b1;
                        w_op_nxt  = CMD_NOP;
                    end else begin
                        w_op_nxt = w_cmd;
                        case (w_cmd)
                            CMD_PUSH: begin
                                w_esact_nxt   = 1'b1;
                                w_esop_nxt    = ES_PUSH;
                                w_pushsrc_nxt = cmd_src;
                                w_done_nxt    = 1'b1;
                                w_inc         = 1'b1;
                            end
                            CMD_POP: begin
                                w_esact_nxt = 1'b1;
                                w_esop_nxt  = ES_POP;
                                w_done_nxt  = 1'b1;
                                w_dec       = 1'b1;
                            end
                            CMD_DUP: begin
                                w_esact_nxt   = 1'b1;
                                w_esop_nxt    = ES_PUSH;
                                w_pushsrc_nxt = SRC_TOSA;
                                w_done_nxt    = 1'b1;
                                w_inc         = 1'b1;
                            end
                            CMD_REPLACE: begin
                                w_esact_nxt   = 1'b1;
                                w_esop_nxt    = ES_WTOP;
                                w_pushsrc_nxt = cmd_src;
                                w_done_nxt    = 1'b1;
                            end
                            CMD_BINOP: begin
                                w_esact_nxt = 1'b1;
                                w_esop_nxt  = ES_POP;
                                w_dec       = 1'b1;
                            end
                            CMD_SWAP: begin
                                w_esact_nxt = 1'b1;
                                w_esop_nxt  = ES_POP;
                            end
                            default: w_done_nxt = 1'b1;
                        endcase
                    end
                end
            end
            ST_OP1: begin
                w_state_nxt = ST_IDLE;
                if (r_op == CMD_BINOP) begin
                    w_state_nxt   = ST_OP2;
                    w_esact_nxt   = 1'b1;
                    w_esop_nxt    = ES_WTOP;
                    w_pushsrc_nxt = SRC_ALU;
                    w_done_nxt    = 1'b1;
                end else if (r_op == CMD_SWAP) begin
                    w_state_nxt   = ST_OP2;
                    w_esact_nxt   = 1'b1;
                    w_esop_nxt    = ES_WTOP;
                    w_pushsrc_nxt = SRC_SEQ;
                    w_seq_nxt     = r_seq_a;
                end
            end
            ST_OP2: begin
                w_state_nxt = ST_IDLE;
                if (r_op == CMD_SWAP) begin
                    w_state_nxt   = ST_OP3;
                    w_esact_nxt   = 1'b1;
                    w_esop_nxt    = ES_PUSH;
                    w_pushsrc_nxt = SRC_SEQ;
                    w_seq_nxt     = r_seq_b;
                    w_done_nxt    = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign ESOp      = r_esop;
    assign ESAct     = r_esact;
    assign pushSrc   = r_pushsrc;
    assign seq_data  = r_seq_data;
    assign depth     = w_depth;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_es_sequencer.sv
// Directed bench for es_sequencer: stimulus queues expected micro-op cycles, a negedge
// monitor pops and compares whenever ESAct, done or err is high.
module tb_es_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [2:0]  cmd_op;
    logic [2:0]  cmd_src;
    logic        cmd_ready;
    logic [15:0] tosRega, tosRegb;
    logic [1:0]  ESOp;
    logic        ESAct;
    logic [2:0]  pushSrc;
    logic [15:0] seq_data;
    logic [4:0]  depth;
    logic        done, err;

    typedef struct {
        logic        act;
        logic [1:0]  op;
        logic [2:0]  src;
        logic        chk_src;
        logic [15:0] seq;
        logic        chk_seq;
        logic        dn;
        logic        er;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    es_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_src   (cmd_src),
        .cmd_ready (cmd_ready),
        .tosRega   (tosRega),
        .tosRegb   (tosRegb),
        .ESOp      (ESOp),
        .ESAct     (ESAct),
        .pushSrc   (pushSrc),
        .seq_data  (seq_data),
        .depth     (depth),
        .done      (done),
        .err       (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void ex(input logic act, input logic [1:0] op, input logic [2:0] src,
                               input logic cs, input logic [15:0] seq, input logic csq,
                               input logic dn, input logic er);
        exp_t e;
        e.act = act; e.op = op; e.src = src; e.chk_src = cs;
        e.seq = seq; e.chk_seq = csq; e.dn = dn; e.er = er;
        q.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (ESAct === 1'b1 || done === 1'b1 || err === 1'b1) begin
            if (q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_event: ESAct=%0b ESOp=%0d done=%0b err=%0b, none expected at %0t",
                         ESAct, ESOp, done, err, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("ESAct", 32'(ESAct), 32'(e.act));
                chk("ESOp", 32'(ESOp), 32'(e.op));
                if (e.chk_src) chk("pushSrc", 32'(pushSrc), 32'(e.src));
                if (e.chk_seq) chk("seq_data", 32'(seq_data), 32'(e.seq));
                chk("done", 32'(done), 32'(e.dn));
                chk("err", 32'(err), 32'(e.er));
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [2:0] src);
        int n;
        n = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (cmd_ready !== 1'b1) chk("ready_timeout", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_src   = src;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // ESOp codes: 0 push, 1 pop, 2 write-top, 3 hold
    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_src = 3'd0;
        tosRega = 16'h0; tosRegb = 16'h0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_ESAct", 32'(ESAct), 32'd0);
        chk("rst_ESOp", 32'(ESOp), 32'd3);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_pushSrc", 32'(pushSrc), 32'd0);
        chk("rst_seq_data", 32'(seq_data), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        for (int s = 1; s <= 7; s++) begin
            ex(1, 2'd0, 3'(s), 1, 16'h0, 0, 1, 0);
            send(3'd1, 3'(s));
        end
        chk("depth_push7", 32'(depth), 32'd7);

        for (int i = 0; i < 5; i++) begin
            ex(1, 2'd1, 3'd0, 0, 16'h0, 0, 1, 0);
            send(3'd2, 3'd0);
        end
        chk("depth_pop5", 32'(depth), 32'd2);

        tosRega = 16'h0003; tosRegb = 16'h0002;
        ex(1, 2'd1, 3'd0, 0, 16'h0, 0, 0, 0);
        ex(1, 2'd2, 3'd6, 1, 16'h0003, 1, 0, 0);
        ex(1, 2'd0, 3'd6, 1, 16'h0002, 1, 1, 0);
        send(3'd4, 3'd0);
        tosRega = 16'hdead; tosRegb = 16'hbeef;
        chk("depth_swap", 32'(depth), 32'd2);

        ex(1, 2'd1, 3'd0, 0, 16'h0, 0, 0, 0);
        ex(1, 2'd2, 3'd1, 1, 16'h0, 0, 1, 0);
        send(3'd5, 3'd0);
        chk("depth_binop", 32'(depth), 32'd1);

        ex(1, 2'd0, 3'd5, 1, 16'h0, 0, 1, 0);
        send(3'd3, 3'd0);
        chk("depth_dup", 32'(depth), 32'd2);

        ex(1, 2'd2, 3'd4, 1, 16'h0, 0, 1, 0);
        send(3'd6, 3'd4);
        chk("depth_replace", 32'(depth), 32'd2);

        ex(0, 2'd3, 3'd0, 0, 16'h0, 0, 1, 0);
        send(3'd0, 3'd0);
        ex(0, 2'd3, 3'd0, 0, 16'h0, 0, 1, 0);
        send(3'd7, 3'd0);
        chk("depth_nop", 32'(depth), 32'd2);

        for (int i = 0; i < 2; i++) begin
            ex(1, 2'd1, 3'd0, 0, 16'h0, 0, 1, 0);
            send(3'd2, 3'd0);
        end
        chk("depth_empty", 32'(depth), 32'd0);

`ifdef ES_DEPTH_CHECK_EN
        ex(0, 2'd3, 3'd0, 0, 16'h0, 0, 0, 1);
        send(3'd2, 3'd0);
        chk("depth_pop_underflow", 32'(depth), 32'd0);
        ex(0, 2'd3, 3'd0, 0, 16'h0, 0, 0, 1);
        send(3'd3, 3'd0);
        chk("depth_dup_empty", 32'(depth), 32'd0);
        for (int i = 0; i < 16; i++) begin
            ex(1, 2'd0, 3'd1, 1, 16'h0, 0, 1, 0);
            send(3'd1, 3'd1);
        end
        chk("depth_full", 32'(depth), 32'd16);
        ex(0, 2'd3, 3'd0, 0, 16'h0, 0, 0, 1);
        send(3'd1, 3'd2);
        chk("depth_push_overflow", 32'(depth), 32'd16);
`else
        ex(1, 2'd1, 3'd0, 0, 16'h0, 0, 1, 0);
        send(3'd2, 3'd0);
        chk("depth_wrap_down", 32'(depth), 32'd31);
        do_reset();
        for (int i = 0; i < 16; i++) begin
            ex(1, 2'd0, 3'd1, 1, 16'h0, 0, 1, 0);
            send(3'd1, 3'd1);
        end
        chk("depth_full", 32'(depth), 32'd16);
        ex(1, 2'd0, 3'd2, 1, 16'h0, 0, 1, 0);
        send(3'd1, 3'd2);
        chk("depth_past_full", 32'(depth), 32'd17);
`endif

        do_reset();
        chk("depth_after_reset", 32'(depth), 32'd0);
        for (int i = 0; i < 2; i++) begin
            ex(1, 2'd0, 3'd7, 1, 16'h0, 0, 1, 0);
            send(3'd1, 3'd7);
        end
        tosRega = 16'h00a5; tosRegb = 16'h005a;
        ex(1, 2'd1, 3'd0, 0, 16'h0, 0, 0, 0);
        ex(1, 2'd2, 3'd6, 1, 16'h00a5, 1, 0, 0);
        send(3'd4, 3'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("midrst_ESAct", 32'(ESAct), 32'd0);
        chk("midrst_ESOp", 32'(ESOp), 32'd3);
        chk("midrst_ready", 32'(cmd_ready), 32'd1);
        chk("midrst_depth", 32'(depth), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        ex(1, 2'd0, 3'd3, 1, 16'h0, 0, 1, 0);
        send(3'd1, 3'd3);
        chk("depth_post_reset_push", 32'(depth), 32'd1);

        repeat (6) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
